imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single combinational-read instruction memory between two requesters:
  - port 0: CPU fetch stage
  - port 1: debug/loader read port
- Arbitrates each cycle, drives the memory word address, and returns registered read data with per-port valid.
- Sits between the fetch logic and the instruction memory. The memory is word-indexed: address N is word N.

Parameters:
- MEM_WORD, 32, data word width in bits.
- ADDR_WIDTH, 32, address width of requester and memory ports.
- MEM_DEPTH, 256, number of valid words; addresses >= MEM_DEPTH are out of range.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- m0_req  input  1  port 0 read request; held with m0_addr until granted.
- m0_addr  input  ADDR_WIDTH  port 0 word address.
- m0_gnt  output  1  port 0 request accepted this cycle (combinational).
- m0_rvalid  output  1  port 0 read data valid (registered).
- m0_rdata  output  MEM_WORD  port 0 read data.
- m0_err  output  1  port 0 out-of-range access flag, qualified by m0_rvalid.
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata, m1_err  same directions, widths and meanings for port 1.
- mem_addr  output  ADDR_WIDTH  address to the instruction memory.
- mem_data  input  MEM_WORD  combinational read data from the instruction memory.

Behaviour:
- Single clock; reset is synchronous, active-high.
- Reset values:
  - m0_rvalid, m1_rvalid, m0_err, m1_err = 0.
  - m0_rdata, m1_rdata = 0.
  - Round-robin pointer last = 1, so port 0 wins the first conflict.
- While rst = 1: m0_gnt = m1_gnt = 0 and mem_addr = 0.
- Arbitration (combinational, cycle N):
  - Only one requester active: it is granted.
  - Both active: grant the port that is not equal to last.
  - Neither active: no grant, and mem_addr = 0.
  - At most one gnt is high per cycle.
- Pointer update: at each rising edge with a grant, last <= granted port index; otherwise last holds.
- mem_addr in cycle N = granted port's address, or 0 if that address is >= MEM_DEPTH.
- Read data (visible cycle N+1):
  - The granted port's rdata <= mem_data, rvalid <= 1, err <= 0.
  - Out of range: rdata <= 0, err <= 1, rvalid <= 1.
- Non-granted port: rvalid <= 0. Its rdata and err hold their last values.
- Latency is exactly 1 cycle from grant to rvalid. Throughput is one access per cycle total, and back-to-back grants to the same port are allowed.
- A requester that sees gnt = 0 keeps req and addr stable. The arbiter does not buffer rejected requests.
- Under continuous requests from both ports, grants alternate 0,1,0,1; neither port waits more than 1 cycle.
- Reset mid-operation:
  - An access granted in the cycle rst is sampled produces no rvalid.
  - The pointer returns to last = 1.
- Boundary addresses:
  - Address MEM_DEPTH-1 is in range.
  - Address MEM_DEPTH is out of range.
  - The compare uses the full ADDR_WIDTH address; no truncation.

Optional Feature:
- Macro: IMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins a conflict; the last pointer is not implemented and has no effect.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then port 0 alone: m0_req = 1, m0_addr = 5, mem[5] = 32'h2402000A.
  - -> m0_gnt = 1 in the same cycle, mem_addr = 5.
  - -> Next cycle m0_rvalid = 1, m0_rdata = 32'h2402000A, m0_err = 0; m1_rvalid = 0.
- Both ports request continuously for 4 cycles, m0_addr = 1, m1_addr = 2.
  - -> Grants are m0, m1, m0, m1.
  - -> rvalid alternates with rdata = mem[1] then mem[2].
  - -> With IMEM_ARB_FIXED_PRIO_EN: m0 is granted all 4 cycles and m1_gnt = 0.
- Port 1 alone, m1_addr = 255 then 256.
  - -> For 255: m1_rdata = mem[255], m1_err = 0.
  - -> For 256: mem_addr = 0, m1_rdata = 0, m1_err = 1, m1_rvalid = 1.
- Both ports request and rst = 1 in the same cycle.
  - -> Both gnt = 0 and no rvalid the next cycle.
  - -> After reset, the first conflict is granted to m0.
- Port 0 requests 3 back-to-back addresses 0, 1, 2 with port 1 idle.
  - -> Grant every cycle.
  - -> m0_rvalid is high for 3 consecutive cycles with mem[0], mem[1], mem[2].
- Idle cycle with both req = 0 after a port 1 grant.
  - -> mem_addr = 0, both rvalid = 0 next cycle, pointer unchanged.
  - -> The next conflict goes to m0.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational-read, word-indexed instruction memory
// between the CPU fetch port (port 0) and a debug/loader read port (port 1).
// Arbitrates every cycle, drives the memory address and returns registered
// read data one cycle after the grant.
//
// Build option: define IMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always
// wins a conflict, no round-robin pointer). Undefined: round-robin.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   mX_req / mX_addr         read request and word address, held until granted
//   mX_gnt                   request accepted this cycle (combinational)
//   mX_rvalid/rdata/err      registered response; err flags an out-of-range address
//   mem_addr                 word address to the instruction memory (0 when idle/out of range)
//   mem_data                 combinational read data from the instruction memory
module imem_arbiter #(
    parameter int unsigned MEM_WORD   = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [MEM_WORD-1:0]   m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [MEM_WORD-1:0]   m1_rdata,
    output logic                  m1_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_WORD-1:0]   mem_data
);

    // Range compare is done at least 32 bits wide so neither the address nor
    // MEM_DEPTH is ever truncated.
    localparam int unsigned CMP_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

    logic                  pick1;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  in_range;

    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [MEM_WORD-1:0]   rdata0_q, rdata0_d;
    logic [MEM_WORD-1:0]   rdata1_q, rdata1_d;
    logic                  err0_q, err0_d;
    logic                  err1_q, err1_d;
`ifndef IMEM_ARB_FIXED_PRIO_EN
    // Index of the most recently granted port; the other port wins a conflict.
    logic                  last_q, last_d;
`endif

    // Grant selection; reset masks both grants.
    always_comb begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
        pick1 = m1_req && !m0_req;
`else
        pick1 = m1_req && (!m0_req || !last_q);
`endif
        m0_gnt = !rst && m0_req && !pick1;
        m1_gnt = !rst && pick1;
    end

    // Memory address: granted port's address, or 0 when idle or out of range.
    always_comb begin
        sel_addr = m1_gnt ? m1_addr : m0_addr;
        in_range = CMP_W'(sel_addr) < CMP_W'(MEM_DEPTH);
        mem_addr = ((m0_gnt || m1_gnt) && in_range) ? sel_addr : '0;
    end

    // Response next-state; a non-granted port keeps its rdata/err.
    always_comb begin
        rvalid0_d = m0_gnt;
        rvalid1_d = m1_gnt;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        if (m0_gnt) begin
            rdata0_d = in_range ? mem_data : '0;
            err0_d   = !in_range;
        end
        if (m1_gnt) begin
            rdata1_d = in_range ? mem_data : '0;
            err1_d   = !in_range;
        end
`ifndef IMEM_ARB_FIXED_PRIO_EN
        last_d = last_q;
        if (m0_gnt) begin
            last_d = 1'b0;
        end else if (m1_gnt) begin
            last_d = 1'b1;
        end
`endif
    end

    // State registers; pointer resets to 1 so port 0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
`ifndef IMEM_ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
`ifndef IMEM_ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    assign m0_rvalid = rvalid0_q;
    assign m0_rdata  = rdata0_q;
    assign m0_err    = err0_q;
    assign m1_rvalid = rvalid1_q;
    assign m1_rdata  = rdata1_q;
    assign m1_err    = err1_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: memory model, round-robin grant model and a
// response scoreboard; each scenario task checks its own results.
module tb_imem_arbiter;

    localparam int unsigned MW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m1_req;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [MW-1:0] m0_rdata, m1_rdata, mem_data;
    logic [AW-1:0] mem_addr;

    logic [MW-1:0] mem [DEPTH];

    typedef struct {
        logic          port;
        logic [MW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    logic model_last;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    // Memory model; a value outside the array marks an illegal address.
    assign mem_data = (mem_addr < AW'(DEPTH)) ? mem[mem_addr[7:0]] : 32'hDEADBEEF;

    imem_arbiter #(.MEM_WORD(MW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    function automatic logic [1:0] exp_gnt(input logic r0, input logic r1);
`ifdef IMEM_ARB_FIXED_PRIO_EN
        return r0 ? 2'b01 : (r1 ? 2'b10 : 2'b00);
`else
        if (r0 && r1) return model_last ? 2'b01 : 2'b10;
        return {r1, r0};
`endif
    endfunction

    // Drives one cycle, captures combinational outputs, pushes the expected
    // response and advances to just after the next rising edge.
    task automatic apply_cycle(input logic r0, input logic [AW-1:0] a0,
                               input logic r1, input logic [AW-1:0] a1,
                               output logic [1:0] obs_g, output logic [1:0] exp_g,
                               output logic [AW-1:0] obs_a, output logic [AW-1:0] exp_a);
        logic [AW-1:0] sa;
        logic          ok;
        m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1;
        #1;
        exp_g = rst ? 2'b00 : exp_gnt(r0, r1);
        sa    = exp_g[1] ? a1 : a0;
        ok    = sa < AW'(DEPTH);
        exp_a = (exp_g != 2'b00 && ok) ? sa : '0;
        obs_g = {m1_gnt, m0_gnt};
        obs_a = mem_addr;
        if (exp_g != 2'b00) begin
            sb.push_back('{port: exp_g[1], data: (ok ? mem[sa[7:0]] : '0), err: !ok});
            model_last = exp_g[1];
        end
        if (rst) model_last = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_next(output logic [1:0] ev, output exp_t e);
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            ev = e.port ? 2'b10 : 2'b01;
        end else begin
            e  = '{port: 1'b0, data: '0, err: 1'b0};
            ev = 2'b00;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m0_req = 1'b1; m0_addr = 32'd3; m1_req = 1'b1; m1_addr = 32'd4;
        #1;
        vecs++; if ({m1_gnt, m0_gnt} !== 2'b00) begin errs++; $display("FAIL reset_gnt got %b want 00", {m1_gnt, m0_gnt}); end
        vecs++; if (mem_addr !== '0) begin errs++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
        repeat (2) @(posedge clk);
        #1;
        vecs++; if ({m1_rvalid, m0_rvalid, m1_err, m0_err} !== 4'b0000) begin
            errs++; $display("FAIL reset_flags got %b want 0000", {m1_rvalid, m0_rvalid, m1_err, m0_err}); end
        vecs++; if ({m1_rdata, m0_rdata} !== 64'd0) begin
            errs++; $display("FAIL reset_rdata got %0h/%0h want 0/0", m1_rdata, m0_rdata); end
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        model_last = 1'b1;
        sb.delete();
    endtask

    task automatic test_conflict;
        logic [1:0] og, eg, ev; logic [AW-1:0] oa, ea; exp_t e;
`ifdef IMEM_ARB_FIXED_PRIO_EN
        logic [1:0] want [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        logic [1:0] want [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        for (int i = 0; i < 4; i++) begin
            apply_cycle(1'b1, 32'd1, 1'b1, 32'd2, og, eg, oa, ea);
            vecs++; if (og !== want[i]) begin errs++; $display("FAIL conflict_gnt[%0d] got %b want %b", i, og, want[i]); end
            vecs++; if (oa !== ea) begin errs++; $display("FAIL conflict_addr[%0d] got %0h want %0h", i, oa, ea); end
            sb_next(ev, e);
            vecs++; if ({m1_rvalid, m0_rvalid} !== ev) begin errs++; $display("FAIL conflict_rvalid[%0d] got %b want %b", i, {m1_rvalid, m0_rvalid}, ev); end
            if (ev[0]) begin vecs++; if (m0_rdata !== e.data) begin errs++; $display("FAIL conflict_rdata0[%0d] got %h want %h", i, m0_rdata, e.data); end end
            if (ev[1]) begin vecs++; if (m1_rdata !== e.data) begin errs++; $display("FAIL conflict_rdata1[%0d] got %h want %h", i, m1_rdata, e.data); end end
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_single;
        logic [1:0] og, eg, ev; logic [AW-1:0] oa, ea; exp_t e;
        apply_cycle(1'b1, 32'd5, 1'b0, 32'd0, og, eg, oa, ea);
        vecs++; if (og !== 2'b01) begin errs++; $display("FAIL single_gnt got %b want 01", og); end
        vecs++; if (oa !== 32'd5) begin errs++; $display("FAIL single_addr got %0h want 5", oa); end
        sb_next(ev, e);
        vecs++; if ({m1_rvalid, m0_rvalid} !== 2'b01) begin errs++; $display("FAIL single_rvalid got %b want 01", {m1_rvalid, m0_rvalid}); end
        vecs++; if ({m0_err, m0_rdata} !== {1'b0, 32'h2402000A}) begin
            errs++; $display("FAIL single_rdata got %b/%h want 0/2402000a", m0_err, m0_rdata); end
        m0_req = 1'b0;
    endtask

    task automatic test_boundary;
        logic [1:0] og, eg, ev; logic [AW-1:0] oa, ea; exp_t e;
        logic [AW-1:0] addrs [3] = '{32'd255, 32'd256, 32'h8000_0005};
        for (int i = 0; i < 3; i++) begin
            apply_cycle(1'b0, 32'd0, 1'b1, addrs[i], og, eg, oa, ea);
            vecs++; if (og !== 2'b10) begin errs++; $display("FAIL bound_gnt[%0d] got %b want 10", i, og); end
            vecs++; if (oa !== ea) begin errs++; $display("FAIL bound_addr[%0d] got %0h want %0h", i, oa, ea); end
            sb_next(ev, e);
            vecs++; if ({m1_rvalid, m0_rvalid} !== ev) begin errs++; $display("FAIL bound_rvalid[%0d] got %b want %b", i, {m1_rvalid, m0_rvalid}, ev); end
            vecs++; if ({m1_err, m1_rdata} !== {e.err, e.data}) begin
                errs++; $display("FAIL bound_resp[%0d] got %b/%h want %b/%h", i, m1_err, m1_rdata, e.err, e.data); end
        end
        vecs++; if (m1_err !== 1'b1) begin errs++; $display("FAIL bound_err_flag got %b want 1", m1_err); end
        m1_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [1:0] og, eg, ev; logic [AW-1:0] oa, ea; exp_t e;
        for (int i = 0; i < 3; i++) begin
            apply_cycle(1'b1, AW'(i), 1'b0, 32'd0, og, eg, oa, ea);
            vecs++; if (og !== 2'b01) begin errs++; $display("FAIL b2b_gnt[%0d] got %b want 01", i, og); end
            sb_next(ev, e);
            vecs++; if ({m1_rvalid, m0_rvalid, m0_rdata} !== {2'b01, mem[i]}) begin
                errs++; $display("FAIL b2b_resp[%0d] got %b/%h want 01/%h", i, {m1_rvalid, m0_rvalid}, m0_rdata, mem[i]); end
        end
        m0_req = 1'b0;
    endtask

    task automatic test_idle;
        logic [1:0] og, eg, ev; logic [AW-1:0] oa, ea; exp_t e;
        apply_cycle(1'b0, 32'd0, 1'b1, 32'd7, og, eg, oa, ea);
        sb_next(ev, e);
        vecs++; if ({m1_rvalid, m1_rdata} !== {1'b1, mem[7]}) begin errs++; $display("FAIL idle_pre got %b/%h want 1/%h", m1_rvalid, m1_rdata, mem[7]); end
        apply_cycle(1'b0, 32'd9, 1'b0, 32'd9, og, eg, oa, ea);
        vecs++; if ({og, oa} !== {2'b00, 32'd0}) begin errs++; $display("FAIL idle_comb got %b/%0h want 00/0", og, oa); end
        sb_next(ev, e);
        vecs++; if ({m1_rvalid, m0_rvalid} !== 2'b00) begin errs++; $display("FAIL idle_rvalid got %b want 00", {m1_rvalid, m0_rvalid}); end
        vecs++; if (m1_rdata !== mem[7]) begin errs++; $display("FAIL idle_hold got %h want %h", m1_rdata, mem[7]); end
        apply_cycle(1'b1, 32'd3, 1'b1, 32'd4, og, eg, oa, ea);
        vecs++; if (og !== 2'b01) begin errs++; $display("FAIL idle_next_conflict got %b want 01", og); end
        sb_next(ev, e);
        vecs++; if ({m0_rvalid, m0_rdata} !== {1'b1, mem[3]}) begin errs++; $display("FAIL idle_next_resp got %b/%h want 1/%h", m0_rvalid, m0_rdata, mem[3]); end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [1:0] og, eg, ev; logic [AW-1:0] oa, ea; exp_t e;
        apply_cycle(1'b1, 32'd10, 1'b1, 32'd11, og, eg, oa, ea);
        sb_next(ev, e);
        vecs++; if ({m1_rvalid, m0_rvalid} !== ev) begin errs++; $display("FAIL rmid_pre got %b want %b", {m1_rvalid, m0_rvalid}, ev); end
        rst = 1'b1;
        apply_cycle(1'b1, 32'd10, 1'b1, 32'd11, og, eg, oa, ea);
        vecs++; if ({og, oa} !== {2'b00, 32'd0}) begin errs++; $display("FAIL rmid_gnt got %b/%0h want 00/0", og, oa); end
        vecs++; if ({m1_rvalid, m0_rvalid} !== 2'b00) begin errs++; $display("FAIL rmid_rvalid got %b want 00", {m1_rvalid, m0_rvalid}); end
        rst = 1'b0;
        apply_cycle(1'b1, 32'd12, 1'b1, 32'd13, og, eg, oa, ea);
        vecs++; if (og !== 2'b01) begin errs++; $display("FAIL rmid_first_conflict got %b want 01", og); end
        sb_next(ev, e);
        vecs++; if ({m0_rvalid, m0_rdata} !== {1'b1, mem[12]}) begin errs++; $display("FAIL rmid_resp got %b/%h want 1/%h", m0_rvalid, m0_rdata, mem[12]); end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m1_req = 1'b0; m1_addr = '0;
        model_last = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] = {8'hC0, 8'(i), 8'(~i), 8'(i * 3)};
        end
        mem[5] = 32'h2402000A;
        test_reset;
        test_conflict;
        test_single;
        test_boundary;
        test_back_to_back;
        test_idle;
        test_reset_mid;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
